// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter. Producers push words through a ready/valid
// handshake into a small FIFO; the transmit FSM drains the FIFO and serialises
// each word back-to-back on o_tx (start bit, DBIT data bits LSB first, optional
// parity bit, stop period). An integrated divider produces the oversample tick
// (16 ticks per bit).
//
// Parameters
//   DBIT     data bits per frame (5..16)
//   PARITY   0 = none, 1 = even, 2 = odd
//   SB_TICK  stop length in oversample ticks (16 / 24 / 32)
//   DIV      clock cycles per oversample tick (>= 2)
//   DIV_W    baud counter width, 2**DIV_W >= DIV
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   i_clock    single clock, rising edge
//   i_reset    synchronous active-high reset
//   i_data     word to transmit
//   i_valid    i_data is valid; taken when o_ready is high
//   o_ready    FIFO can accept a word (not full)
//   o_tx       serial line, idle high, registered
//   o_tx_done  one-cycle pulse at the end of every frame, registered
//   o_busy     FSM active or FIFO holds data
//   o_count    FIFO occupancy, 0..2**FIFO_AW
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int PARITY  = 0,
  parameter int SB_TICK = 16,
  parameter int DIV     = 163,
  parameter int DIV_W   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [DBIT-1:0]    i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy,
  output logic [FIFO_AW:0]   o_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0]     S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0]     S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]     N_LAST      = N_W'(DBIT - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [FIFO_AW:0]   DEPTH_CNT   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DBIT-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               avail_q;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  // A full FIFO refuses the word even if the FSM pops in the same cycle.
  assign push  = i_valid && !full;

  // NOTE: the storage array has no reset; contents are only ever read behind
  // the occupancy count, so clearing the pointers is enough to discard them.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      avail_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // The FSM launches from this registered copy of "not empty", so a word
      // pushed at edge N is counted at N+1 and starts its frame at N+2.
      avail_q <= !empty;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud tick generator: held at zero while idle, so the first tick of every
  // frame lands exactly DIV cycles after leaving IDLE.
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;

  assign tick = (baud_cnt == DIV_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset || state == S_IDLE) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  logic [S_W-1:0]  s_cnt;
  logic [S_W-1:0]  s_cnt_n;
  logic [N_W-1:0]  n_cnt;
  logic [N_W-1:0]  n_cnt_n;
  logic [DBIT-1:0] shift;
  logic [DBIT-1:0] shift_n;
  logic            par;
  logic            par_n;
  logic            tx_q;
  logic            tx_n;
  logic            done_q;
  logic            done_n;
  logic [DBIT-1:0] head;

  assign head = mem[rd_ptr];

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    shift_n = shift;
    par_n   = par;
    tx_n    = tx_q;
    done_n  = 1'b0;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (avail_q && !empty) begin
          pop     = 1'b1;
          shift_n = head;
          // Parity is fixed at load time from the whole word.
          par_n   = (PARITY == 2) ? ~^head : ^head;
          s_cnt_n = '0;
          n_cnt_n = '0;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (s_cnt == S_BIT_LAST) begin
            s_cnt_n = '0;
            n_cnt_n = '0;
            tx_n    = shift[0];
            state_n = S_DATA;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (s_cnt == S_BIT_LAST) begin
            s_cnt_n = '0;
            shift_n = shift >> 1;
            if (n_cnt == N_LAST) begin
              if (PARITY != 0) begin
                tx_n    = par;
                state_n = S_PARITY;
              end else begin
                tx_n    = 1'b1;
                state_n = S_STOP;
              end
            end else begin
              n_cnt_n = n_cnt + 1'b1;
              tx_n    = shift_n[0];
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          if (s_cnt == S_BIT_LAST) begin
            s_cnt_n = '0;
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      S_STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (s_cnt == S_STOP_LAST) begin
            s_cnt_n = '0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= S_IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      shift  <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      s_cnt  <= s_cnt_n;
      n_cnt  <= n_cnt_n;
      shift  <= shift_n;
      par    <= par_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ready   = !full;
  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = (state != S_IDLE) || !empty;
  assign o_count   = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Three instances of uart_tx_fifo with different configurations (all DIV=4):
//   dut 0: DBIT=8, no parity, SB_TICK=16, FIFO_AW=2
//   dut 1: DBIT=7, odd parity, SB_TICK=16, FIFO_AW=2
//   dut 2: DBIT=8, no parity, SB_TICK=32, FIFO_AW=2
// Stimulus pushes hand-computed expected frames into a scoreboard queue; a
// monitor decodes the selected serial line and compares each frame it sees.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int BIT = 64;  // 16 ticks * DIV(4)

  typedef struct {
    int bits;  // line bits, bit 0 = start bit, through the last data/parity bit
    int nb;    // number of sampled line bits
    int f;     // frame length in cycles from the falling edge
    int hi;    // expected high cycles since previous frame's last bit, -1 = any
  } frame_t;

  logic            clk = 1'b0;
  int              cyc = 0;
  logic [2:0]      reset_r;
  logic [2:0]      valid_r;
  logic [2:0][15:0] data_r;
  logic [2:0]      tx_w;
  logic [2:0]      done_w;
  logic [2:0]      ready_w;
  logic [2:0]      busy_w;
  logic [2:0][2:0] cnt_w;

  int     total = 0;
  int     bad   = 0;
  int     done_cnt [3];
  int     sel   = 0;
  logic   mon_en = 1'b1;
  logic   mon_busy = 1'b0;
  frame_t exp_q [$];

  logic mon_tx;
  logic mon_done;
  assign mon_tx   = tx_w[sel];
  assign mon_done = done_w[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int d = 0; d < 3; d++) done_cnt[d] = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done_w[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  uart_tx_fifo #(.DBIT(8), .PARITY(0), .SB_TICK(16), .DIV(4), .DIV_W(3), .FIFO_AW(2)) dut_a (
    .i_clock(clk), .i_reset(reset_r[0]), .i_data(data_r[0][7:0]), .i_valid(valid_r[0]),
    .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_tx_done(done_w[0]), .o_busy(busy_w[0]),
    .o_count(cnt_w[0])
  );

  uart_tx_fifo #(.DBIT(7), .PARITY(2), .SB_TICK(16), .DIV(4), .DIV_W(3), .FIFO_AW(2)) dut_b (
    .i_clock(clk), .i_reset(reset_r[1]), .i_data(data_r[1][6:0]), .i_valid(valid_r[1]),
    .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_tx_done(done_w[1]), .o_busy(busy_w[1]),
    .o_count(cnt_w[1])
  );

  uart_tx_fifo #(.DBIT(8), .PARITY(0), .SB_TICK(32), .DIV(4), .DIV_W(3), .FIFO_AW(2)) dut_c (
    .i_clock(clk), .i_reset(reset_r[2]), .i_data(data_r[2][7:0]), .i_valid(valid_r[2]),
    .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_tx_done(done_w[2]), .o_busy(busy_w[2]),
    .o_count(cnt_w[2])
  );

  task automatic check(input string name, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, expv, expv, cyc);
    end
  endtask

  function automatic frame_t mk(input int bits, input int f, input int hi);
    frame_t fr;
    fr.bits = bits;
    fr.nb   = 9;
    fr.f    = f;
    fr.hi   = hi;
    return fr;
  endfunction

  // Called at a negedge; presents one word for one edge and returns the edge
  // number at which it was offered. valid stays high until the caller drops it.
  task automatic push(input int d, input logic [15:0] w, input logic exp_ready,
                      input logic enq, input frame_t fr, output int acc);
    data_r[d]  = w;
    valid_r[d] = 1'b1;
    check("ready_before_push", int'(ready_w[d]), int'(exp_ready));
    if (exp_ready && enq) exp_q.push_back(fr);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() + int'(mon_busy), 0);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: decodes frames on the selected line and scores them.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic   prev;
    int     e0;
    int     last_data_end;
    int     got;
    int     n_stop_bad;
    frame_t fr;
    prev = 1'b1;
    last_data_end = 0;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && mon_tx === 1'b0) begin
        e0 = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          mon_busy = 1'b1;
          fr = exp_q.pop_front();
          if (fr.hi >= 0) check("idle_gap", e0 - last_data_end, fr.hi);
          got = 0;
          repeat (BIT / 2) @(negedge clk);
          if (mon_tx === 1'b1) got = got | 1;
          for (int i = 1; i < fr.nb; i++) begin
            repeat (BIT) @(negedge clk);
            if (mon_tx === 1'b1) got = got | (1 << i);
          end
          check("frame_bits", got, fr.bits);
          n_stop_bad = 0;
          while (cyc < e0 + fr.f - 1) begin
            @(negedge clk);
            if (mon_done !== 1'b0) n_stop_bad++;
            if (cyc >= e0 + BIT * fr.nb && mon_tx !== 1'b1) n_stop_bad++;
          end
          check("stop_hold", n_stop_bad, 0);
          @(negedge clk);
          check("done_pulse", int'(mon_done), 1);
          last_data_end = e0 + BIT * fr.nb;
          mon_busy = 1'b0;
        end
      end
      prev = mon_tx;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int acc;
    int acc0;
    int e0;
    int base;
    int n_bad;
    frame_t none;
    none = mk(0, 0, -1);

    reset_r = 3'b111;
    valid_r = 3'b000;
    data_r  = '0;
    repeat (2) @(negedge clk);
    reset_r = 3'b000;

    // Reset state and idle behaviour.
    check("rst_tx", int'(tx_w[0]), 1);
    check("rst_ready", int'(ready_w[0]), 1);
    check("rst_count", int'(cnt_w[0]), 0);
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);
    n_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || cnt_w[0] !== 3'd0 ||
          busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) n_bad++;
    end
    check("idle_100", n_bad, 0);
    check("idle_done_cnt", done_cnt[0], 0);

    // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1 then stop, F = 640.
    sel = 0;
    push(0, 16'h00A5, 1'b1, 1'b1, mk(32'h14A, 640, -1), acc);
    valid_r[0] = 1'b0;
    check("count_after_push", int'(cnt_w[0]), 1);
    check("busy_after_push", int'(busy_w[0]), 1);
    @(negedge clk);
    check("tx_high_at_n1", int'(tx_w[0]), 1);
    @(negedge clk);
    check("tx_fall_at_n2", int'(tx_w[0]), 0);
    check("count_after_launch", int'(cnt_w[0]), 0);
    drain(2000);
    check("single_done_cnt", done_cnt[0], 1);
    check("single_busy_end", int'(busy_w[0]), 0);

    // Odd parity, DBIT=7, 0x03: data 1,1,0,0,0,0,0, parity 1.
    sel = 1;
    push(1, 16'h0003, 1'b1, 1'b1, mk(32'h106, 640, -1), acc);
    valid_r[1] = 1'b0;
    drain(2000);
    check("parity_done_cnt", done_cnt[1], 1);

    // Full FIFO: six offers back to back, the sixth is refused.
    sel = 0;
    base = done_cnt[0];
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("count_full", int'(cnt_w[0]), 4);
      push(0, 16'((i + 1) * 8'h11), (i < 5), 1'b1,
           mk(((i + 1) * 8'h11) << 1, 640, (i == 0) ? -1 : 65), acc);
    end
    valid_r[0] = 1'b0;
    drain(5000);
    check("full_done_cnt", done_cnt[0] - base, 5);
    check("full_busy_end", int'(busy_w[0]), 0);
    check("full_count_end", int'(cnt_w[0]), 0);

    // Reset in the middle of data bit 3 with two words still queued.
    mon_en = 1'b0;
    base = done_cnt[0];
    push(0, 16'h0000, 1'b1, 1'b0, none, acc0);
    push(0, 16'h005A, 1'b1, 1'b0, none, acc);
    push(0, 16'h003C, 1'b1, 1'b0, none, acc);
    valid_r[0] = 1'b0;
    e0 = acc0 + 2;
    while (cyc < e0 + BIT * 4 + 20) @(negedge clk);
    check("mid_tx_bit3", int'(tx_w[0]), 0);
    check("mid_count_queued", int'(cnt_w[0]), 2);
    reset_r[0] = 1'b1;
    @(negedge clk);
    reset_r[0] = 1'b0;
    check("mid_rst_tx", int'(tx_w[0]), 1);
    check("mid_rst_count", int'(cnt_w[0]), 0);
    check("mid_rst_busy", int'(busy_w[0]), 0);
    check("mid_rst_ready", int'(ready_w[0]), 1);
    n_bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) n_bad++;
    end
    check("mid_quiet_after", n_bad, 0);
    check("mid_no_done", done_cnt[0] - base, 0);
    mon_en = 1'b1;

    // Two stop bits: 0xFF then 0x00, high period between frames 128 + 1.
    sel = 2;
    repeat (2) @(negedge clk);
    push(2, 16'h00FF, 1'b1, 1'b1, mk(32'h1FE, 704, -1), acc);
    push(2, 16'h0000, 1'b1, 1'b1, mk(32'h000, 704, 129), acc);
    valid_r[2] = 1'b0;
    drain(3000);
    check("stop_done_cnt", done_cnt[2], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter with an integrated baud-tick generator, a TX FIFO, configurable data width, optional parity and configurable stop length. It is the next-generation TX path: producers push words with a ready/valid handshake, and the block serialises them back-to-back on `o_tx` with no per-frame `tx_start` pulse. It sits between the CPU/debug logic and the board UART pin.

## Interface

Parameters:
- `DBIT`, 8: data bits per frame, legal 5..16; sent LSB first.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `SB_TICK`, 16: stop length in oversample ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `DIV`, 163: clock cycles per oversample tick (16 ticks per bit), ≥2.
- `DIV_W`, 8: baud counter width; must satisfy 2^DIV_W ≥ DIV.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW.

Ports:
- `i_clock` in 1: single clock; everything is on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_data` in DBIT: word to transmit.
- `i_valid` in 1: `i_data` is valid.
- `o_ready` in/out: out 1: FIFO can accept; equals !full.
- `o_tx` out 1: serial line, idle high.
- `o_tx_done` out 1: one-cycle pulse at the end of each frame.
- `o_busy` out 1: FSM not IDLE, or FIFO not empty.
- `o_count` out FIFO_AW+1: FIFO occupancy, 0..2^FIFO_AW.

## Operation

- **Reset values.** When `i_reset` is high at an edge:
  - `o_tx`=1, `o_tx_done`=0, `o_busy`=0, `o_count`=0, `o_ready`=1.
  - FSM goes to IDLE and the baud counter clears.
  - FIFO contents are discarded.
  - Reset mid-frame aborts the frame: `o_tx` is high from the next edge, and no `o_tx_done` pulse is produced.
- **Push.** A word is accepted at an edge where `i_valid && o_ready`.
  - When full, `o_ready`=0 and the word is not taken, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves `o_count` unchanged.
  - Pointers wrap modulo depth.
- **Baud counter.**
  - Held at 0 in IDLE.
  - Otherwise it counts 0..DIV-1 and wraps. `tick` is high when the count is DIV-1.
  - The first tick of a frame therefore arrives exactly DIV cycles after leaving IDLE.
- **FSM states and transitions.**
  - IDLE: `o_tx`=1. If FIFO not empty: load the head word into the shift register, pop, clear the tick counter, set `o_tx`=0, go to START.
  - START: after 16 ticks go to DATA with bit index 0 and `o_tx`=shift[0].
  - DATA: every 16 ticks shift right and increment the index. After bit DBIT-1 completes, go to PARITY (PARITY≠0) or STOP.
  - PARITY: `o_tx` = XOR of the data bits (even) or its inverse (odd); held for 16 ticks, then go to STOP.
  - STOP: `o_tx`=1 for SB_TICK ticks, then go to IDLE with `o_tx_done`=1 for exactly one cycle.
- **Outputs.** `o_tx` is registered (glitch-free). `o_tx_done` is registered.

## Timing

- Push into an empty, idle block at edge N: `o_tx` falls at edge N+2, because the FIFO count is visible at N+1 and IDLE launches at that edge.
- Let E0 be the `o_tx` falling edge.
  - Bit k (start = bit 0) begins at E0 + 16·DIV·k.
  - The frame ends at E0 + F, where F = (1 + DBIT + (PARITY≠0))·16·DIV + SB_TICK·DIV. `o_tx_done` is high in the cycle after edge E0+F.
- Back-to-back frames: if the FIFO is non-empty at frame end, the next start bit falls at E0+F+1. This gives exactly one extra idle-high cycle between frames; the rate is otherwise continuous.
- Push during transmission never disturbs the frame in flight.

## Test plan

- **Reset and idle.**
  - Stimulus: reset for 2 cycles, hold `i_valid`=0 for 100 cycles.
  - Required: `o_tx`=1, `o_ready`=1, `o_count`=0, `o_busy`=0, no `o_tx_done`.
- **Single frame.**
  - Config: DIV=4, DBIT=8, PARITY=0, SB_TICK=16.
  - Stimulus: push 0xA5.
  - Required: `o_tx` falls 2 cycles after accept; line reads 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; `o_tx_done` 640 cycles after the fall.
- **Parity.**
  - Config: PARITY=2 (odd), DBIT=7.
  - Stimulus: push 0x03.
  - Required: parity bit 1; frame F=(1+7+1)·64+64=640 cycles.
- **Full FIFO.**
  - Config: FIFO_AW=2.
  - Stimulus: push 6 words with `i_valid` held high.
  - Required: `o_ready` drops when `o_count`=4 while the first word is already transmitting (5 accepted). All 5 transmit in order, with 1-cycle inter-frame gaps and 5 `o_tx_done` pulses.
- **Reset mid-frame.**
  - Stimulus: assert `i_reset` during DATA bit 3 with 2 words queued.
  - Required: `o_tx`=1 from the next edge, `o_count`=0, no `o_tx_done`, and nothing transmits afterwards.
- **Stop length.**
  - Config: SB_TICK=32, DIV=4.
  - Stimulus: push 0xFF, 0x00 back-to-back.
  - Required: high period between the last data bit of frame 1 and the start of frame 2 is 128+1 cycles.
